// File: rtl/cpu_bus_serializer.sv
// Serialises one parallel CPU access into a narrow pin frame:
// address beats, command beat, ready wait (with optional timeout), data beats.
module cpu_bus_serializer #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int PIN_W    = 8,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic              ext_frame,
  output logic [PIN_W-1:0]  ext_out,
  output logic [PIN_W-1:0]  ext_io_out,
  output logic [PIN_W-1:0]  ext_io_oe,
  input  logic [PIN_W-1:0]  ext_io_in,
  input  logic              ext_rdy
);

  localparam int NA     = ADDR_W / PIN_W;
  localparam int ND     = DATA_W / PIN_W;
  localparam int MAXB   = (NA > ND) ? NA : ND;
  localparam int BEAT_W = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam int TMO_W  = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [BEAT_W-1:0] ADDR_LAST = BEAT_W'(NA - 1);
  localparam logic [BEAT_W-1:0] DATA_LAST = BEAT_W'(ND - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_CMD, S_WAIT, S_DATA, S_DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [BEAT_W-1:0]   beat_reg, beat_next;
  logic [TMO_W-1:0]    tmo_reg, tmo_next;
  logic                err_reg, err_next;
  logic                we_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [DATA_W-1:0]   rdata_shift_reg, rdata_shift_next;

  logic [DATA_W-1:0]   cpu_rdata_reg, cpu_rdata_next;
  logic                cpu_ack_reg, cpu_ack_next;
  logic                cpu_err_reg, cpu_err_next;
  logic                ext_frame_reg, ext_frame_next;
  logic [PIN_W-1:0]    ext_out_reg, ext_out_next;
  logic [PIN_W-1:0]    ext_io_out_reg, ext_io_out_next;
  logic [PIN_W-1:0]    ext_io_oe_reg, ext_io_oe_next;

  // The first address beat is registered on the accepting edge, before addr_reg holds it.
  logic [ADDR_W-1:0]   addr_src;
  logic [PIN_W-1:0]    addr_slice [NA];
  logic [PIN_W-1:0]    wdata_slice [ND];
  logic [1:0]          cmd_bits;

  assign addr_src = (state_reg == S_IDLE) ? cpu_addr : addr_reg;
  assign cmd_bits = {we_reg, 1'b1};

  genvar gi;
  generate
    for (gi = 0; gi < NA; gi++) begin : g_addr_slice
      assign addr_slice[gi] = addr_src[gi*PIN_W +: PIN_W];
    end
    for (gi = 0; gi < ND; gi++) begin : g_wdata_slice
      assign wdata_slice[gi] = wdata_reg[gi*PIN_W +: PIN_W];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    tmo_next   = tmo_reg;
    err_next   = err_reg;
    case (state_reg)
      S_IDLE: if (cpu_req) begin
        state_next = S_ADDR;
        beat_next  = '0;
        tmo_next   = '0;
        err_next   = 1'b0;
      end
      S_ADDR: if (beat_reg == ADDR_LAST) begin
        state_next = S_CMD;
        beat_next  = '0;
      end else begin
        beat_next  = beat_reg + 1'b1;
      end
      S_CMD: begin
        state_next = S_WAIT;
        tmo_next   = '0;
      end
      S_WAIT: if (ext_rdy) begin
        state_next = S_DATA;
        beat_next  = '0;
      end else if (WAIT_MAX != 0 && tmo_reg == TMO_LAST) begin
        state_next = S_DONE;
        err_next   = 1'b1;
      end else begin
        tmo_next   = tmo_reg + 1'b1;
      end
      S_DATA: if (beat_reg == DATA_LAST) begin
        state_next = S_DONE;
      end else begin
        beat_next  = beat_reg + 1'b1;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    ext_frame_next  = (state_next != S_IDLE) && (state_next != S_DONE);
    ext_out_next    = '0;
    ext_io_out_next = '0;
    ext_io_oe_next  = '0;
    case (state_next)
      S_ADDR: ext_out_next = addr_slice[beat_next];
      S_CMD:  ext_out_next = PIN_W'(cmd_bits);
      S_DATA: if (we_reg) begin
        ext_io_out_next = wdata_slice[beat_next];
        ext_io_oe_next  = '1;
      end
      default: ;
    endcase
    cpu_ack_next = (state_next == S_DONE);
    cpu_err_next = (state_next == S_DONE) && err_next;

    // Read beats shift in from the top so beat 0 ends up in the LSB slice.
    rdata_shift_next = rdata_shift_reg;
    if (state_reg == S_DATA && !we_reg)
      rdata_shift_next = DATA_W'({ext_io_in, rdata_shift_reg} >> PIN_W);
    cpu_rdata_next = cpu_rdata_reg;
    if (state_next == S_DONE && !err_next && !we_reg)
      cpu_rdata_next = rdata_shift_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      beat_reg        <= '0;
      tmo_reg         <= '0;
      err_reg         <= 1'b0;
      we_reg          <= 1'b0;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      rdata_shift_reg <= '0;
      cpu_rdata_reg   <= '0;
      cpu_ack_reg     <= 1'b0;
      cpu_err_reg     <= 1'b0;
      ext_frame_reg   <= 1'b0;
      ext_out_reg     <= '0;
      ext_io_out_reg  <= '0;
      ext_io_oe_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      beat_reg        <= beat_next;
      tmo_reg         <= tmo_next;
      err_reg         <= err_next;
      rdata_shift_reg <= rdata_shift_next;
      cpu_rdata_reg   <= cpu_rdata_next;
      cpu_ack_reg     <= cpu_ack_next;
      cpu_err_reg     <= cpu_err_next;
      ext_frame_reg   <= ext_frame_next;
      ext_out_reg     <= ext_out_next;
      ext_io_out_reg  <= ext_io_out_next;
      ext_io_oe_reg   <= ext_io_oe_next;
      if (state_reg == S_IDLE && cpu_req) begin
        we_reg    <= cpu_we;
        addr_reg  <= cpu_addr;
        wdata_reg <= cpu_wdata;
      end
    end
  end

  assign cpu_rdata  = cpu_rdata_reg;
  assign cpu_ack    = cpu_ack_reg;
  assign cpu_err    = cpu_err_reg;
  assign ext_frame  = ext_frame_reg;
  assign ext_out    = ext_out_reg;
  assign ext_io_out = ext_io_out_reg;
  assign ext_io_oe  = ext_io_oe_reg;

endmodule
